// File: rtl/fetch_pkg.sv
// Field layout of a processor instruction: {op_code, reg_s, acc_s, val}.
// Shared by the fetch unit and the execute-stage decoder.
package fetch_pkg;

    localparam int INSTR_W_DEF = 16;
    localparam int OPC_W_DEF   = 6;

    function automatic int reg_s_pos(input int instr_w, input int opc_w);
        return instr_w - opc_w - 1;
    endfunction

    function automatic int acc_s_pos(input int instr_w, input int opc_w);
        return instr_w - opc_w - 2;
    endfunction

    function automatic int val_w(input int instr_w, input int opc_w);
        return instr_w - opc_w - 2;
    endfunction

    localparam int VAL_W_DEF = val_w(INSTR_W_DEF, OPC_W_DEF);

    typedef struct packed {
        logic [OPC_W_DEF-1:0] op_code;
        logic                 reg_s;
        logic                 acc_s;
        logic [VAL_W_DEF-1:0] val;
    } decoded_t;

    function automatic decoded_t decode(input logic [INSTR_W_DEF-1:0] instr);
        decoded_t d;
        d.op_code = instr[INSTR_W_DEF-1 -: OPC_W_DEF];
        d.reg_s   = instr[reg_s_pos(INSTR_W_DEF, OPC_W_DEF)];
        d.acc_s   = instr[acc_s_pos(INSTR_W_DEF, OPC_W_DEF)];
        d.val     = instr[VAL_W_DEF-1:0];
        return d;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Show-ahead FIFO of fetched {pc, instr} entries with a whole-queue flush.
// Flush dominates push and pop in the same cycle.
module fetch_queue #(
    parameter  int W     = 26,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic          valid,
    output logic [CW-1:0] count
);

    logic [W-1:0]  store_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign push_ok = push && (count_q != CW'(DEPTH));
    assign pop_ok  = pop && (count_q != '0);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) store_q[wr_ptr_q] <= push_data;
    end

    assign head  = store_q[rd_ptr_q];
    assign valid = (count_q != '0);
    assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Processor front end: PC, loadable instruction memory, credit-based prefetch
// into a small queue, and a decoded head instruction for the execute stage.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 10,
    parameter int                INSTR_W  = 16,
    parameter int                OPC_W    = 6,
    parameter int                QDEPTH   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    localparam int               CNT_W    = $clog2(QDEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load_en,
    input  logic [ADDR_W-1:0]         load_addr,
    input  logic [INSTR_W-1:0]        load_data,
    input  logic                      branch,
    input  logic [ADDR_W-1:0]         br_address,
    input  logic                      stall,
    output logic                      instr_valid,
    output logic [INSTR_W-1:0]        instr,
    output logic [ADDR_W-1:0]         instr_pc,
    output logic [OPC_W-1:0]          op_code,
    output logic                      reg_s,
    output logic                      acc_s,
    output logic [INSTR_W-OPC_W-3:0]  val,
    output logic [CNT_W-1:0]          dbg_count
);

    localparam int REG_S_POS = reg_s_pos(INSTR_W, OPC_W);
    localparam int ACC_S_POS = acc_s_pos(INSTR_W, OPC_W);
    localparam int VAL_W     = val_w(INSTR_W, OPC_W);
    localparam int E_W       = ADDR_W + INSTR_W;

    logic [INSTR_W-1:0] mem_q [2**ADDR_W];
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  rd_pc_q;
    logic [INSTR_W-1:0] rd_data_q;
    logic               inflight_q, inflight_d;
    logic               flush, issue, push, pop;
    logic               q_valid;
    logic [CNT_W-1:0]   q_count;
    logic [CNT_W:0]     credits_used;
    logic [E_W-1:0]     head;

    // Handshake: the head transfers on a cycle where instr_valid is high and
    // stall is low; any flush source in that cycle cancels the transfer.
    assign flush        = reset || load_en || branch;
    assign credits_used = {1'b0, q_count} + {{CNT_W{1'b0}}, inflight_q};
    assign issue        = !flush && (credits_used < (CNT_W+1)'(QDEPTH));
    assign push         = inflight_q && !flush;
    assign pop          = q_valid && !stall && !flush;
    assign inflight_d   = issue;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (reset || load_en)
            fetch_pc_d = RESET_PC;
        else if (branch)
            fetch_pc_d = br_address;
        else if (issue)
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
        end
    end

    // Memory contents survive reset; only the load port writes them.
    always_ff @(posedge clk) begin
        if (load_en) mem_q[load_addr] <= load_data;
        if (issue) begin
            rd_data_q <= mem_q[fetch_pc_q];
            rd_pc_q   <= fetch_pc_q;
        end
    end

    fetch_queue #(
        .W     (E_W),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .push_data ({rd_pc_q, rd_data_q}),
        .pop       (pop),
        .head      (head),
        .valid     (q_valid),
        .count     (q_count)
    );

    assign instr_valid = q_valid;
    assign instr       = q_valid ? head[INSTR_W-1:0] : '0;
    assign instr_pc    = q_valid ? head[E_W-1:INSTR_W] : '0;
    assign op_code     = instr[INSTR_W-1 -: OPC_W];
    assign reg_s       = instr[REG_S_POS];
    assign acc_s       = instr[ACC_S_POS];
    assign val         = instr[VAL_W-1:0];
    assign dbg_count   = q_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: load, streaming, stall fill, branch,
// wrap-around, and mid-stream reset/load flushes.
module tb_instr_fetch_unit;

    localparam int ADDR_W  = 10;
    localparam int INSTR_W = 16;
    localparam int OPC_W   = 6;
    localparam int QDEPTH  = 4;
    localparam int CNT_W   = $clog2(QDEPTH) + 1;

    logic                     clk;
    logic                     reset;
    logic                     load_en;
    logic [ADDR_W-1:0]        load_addr;
    logic [INSTR_W-1:0]       load_data;
    logic                     branch;
    logic [ADDR_W-1:0]        br_address;
    logic                     stall;
    logic                     instr_valid;
    logic [INSTR_W-1:0]       instr;
    logic [ADDR_W-1:0]        instr_pc;
    logic [OPC_W-1:0]         op_code;
    logic                     reg_s;
    logic                     acc_s;
    logic [INSTR_W-OPC_W-3:0] val;
    logic [CNT_W-1:0]         dbg_count;

    int total = 0;
    int bad   = 0;

    instr_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .OPC_W    (OPC_W),
        .QDEPTH   (QDEPTH),
        .RESET_PC ('0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .branch      (branch),
        .br_address  (br_address),
        .stall       (stall),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .op_code     (op_code),
        .reg_s       (reg_s),
        .acc_s       (acc_s),
        .val         (val),
        .dbg_count   (dbg_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Program image: four hand-written words at 0..3, a marker pattern elsewhere.
    function automatic logic [INSTR_W-1:0] exp_word(input logic [ADDR_W-1:0] a);
        case (a)
            10'd0:   return 16'h040D;
            10'd1:   return 16'h280C;
            10'd2:   return 16'h2C14;
            10'd3:   return 16'h080D;
            default: return 16'hA300 | {8'h00, a[7:0]};
        endcase
    endfunction

    task automatic load_word(input logic [ADDR_W-1:0] a);
        load_en   = 1'b1;
        load_addr = a;
        load_data = exp_word(a);
        @(negedge clk);
    endtask

    // Returns at the negedge where reset was dropped; that is cycle 0.
    task automatic restart();
        @(negedge clk);
        stall  = 1'b0;
        branch = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        total++; if (instr !== 16'h0000) begin bad++; $display("FAIL reset_instr: got %h want 0000", instr); end
        total++; if (instr_pc !== 10'h000) begin bad++; $display("FAIL reset_pc: got %h want 000", instr_pc); end
        total++; if (dbg_count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", dbg_count); end
    endtask

    task automatic test_load_stream();
        reset = 1'b0;
        for (int a = 0; a < 16; a++) load_word(ADDR_W'(a));
        for (int a = 1008; a < 1024; a++) load_word(ADDR_W'(a));
        load_en = 1'b0;
        @(negedge clk);
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL load_c1_valid: got %b want 0", instr_valid); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++; if (instr_pc !== ADDR_W'(c) || instr_valid !== 1'b1) begin
                bad++; $display("FAIL stream_pc: got %h/%b want %h/1", instr_pc, instr_valid, c);
            end
            total++; if (instr !== exp_word(ADDR_W'(c))) begin
                bad++; $display("FAIL stream_instr: got %h want %h", instr, exp_word(ADDR_W'(c)));
            end
            if (c == 1) begin
                total++; if (op_code !== 6'h0A || reg_s !== 1'b0 || acc_s !== 1'b0 || val !== 8'h0C) begin
                    bad++; $display("FAIL decode_280C: got %h %b %b %h want 0a 0 0 0c", op_code, reg_s, acc_s, val);
                end
            end
        end
    endtask

    task automatic test_stall_fill();
        restart();
        repeat (3) @(negedge clk);
        total++; if (instr_pc !== 10'd1) begin bad++; $display("FAIL fill_pre_pc: got %h want 001", instr_pc); end
        stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++; if (instr_pc !== 10'd1 || instr !== 16'h280C || instr_valid !== 1'b1) begin
                bad++; $display("FAIL fill_hold: got pc %h instr %h want 001 280c", instr_pc, instr);
            end
            if (i == 2 || i == 9) begin
                total++; if (dbg_count !== 3'd4) begin bad++; $display("FAIL fill_count: got %0d want 4", dbg_count); end
            end
        end
        stall = 1'b0;
        for (int a = 2; a <= 5; a++) begin
            @(negedge clk);
            total++; if (instr_pc !== ADDR_W'(a) || instr_valid !== 1'b1) begin
                bad++; $display("FAIL fill_release_pc: got %h/%b want %h/1", instr_pc, instr_valid, a);
            end
            if (a == 4) begin
                total++; if (op_code !== 6'h28 || reg_s !== 1'b1 || acc_s !== 1'b1 || val !== 8'h04) begin
                    bad++; $display("FAIL decode_A304: got %h %b %b %h want 28 1 1 04", op_code, reg_s, acc_s, val);
                end
            end
        end
    endtask

    task automatic test_branch();
        restart();
        repeat (2) @(negedge clk);
        stall = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (dbg_count !== 3'd3 || instr_pc !== 10'd0) begin
            bad++; $display("FAIL br_pre: got count %0d pc %h want 3 000", dbg_count, instr_pc);
        end
        branch     = 1'b1;
        br_address = 10'h3F0;
        stall      = 1'b0;
        @(negedge clk);
        branch = 1'b0;
        total++; if (instr_valid !== 1'b0 || dbg_count !== 3'd0) begin
            bad++; $display("FAIL br_flush: got valid %b count %0d want 0 0", instr_valid, dbg_count);
        end
        @(negedge clk);
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL br_bubble2: got %b want 0", instr_valid); end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            total++; if (instr_pc !== 10'h3F0 + ADDR_W'(j) || instr !== exp_word(10'h3F0 + ADDR_W'(j))) begin
                bad++; $display("FAIL br_target: got %h %h want %h", instr_pc, instr, 10'h3F0 + ADDR_W'(j));
            end
        end
    endtask

    task automatic test_wrap_branch_stall();
        branch     = 1'b1;
        br_address = 10'h3FF;
        @(negedge clk);
        branch = 1'b0;
        @(negedge clk);
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL wrap_bubble: got %b want 0", instr_valid); end
        @(negedge clk);
        total++; if (instr_pc !== 10'h3FF || instr !== 16'hA3FF) begin
            bad++; $display("FAIL wrap_3ff: got %h %h want 3ff a3ff", instr_pc, instr);
        end
        @(negedge clk);
        total++; if (instr_pc !== 10'h000 || instr !== 16'h040D) begin
            bad++; $display("FAIL wrap_000: got %h %h want 000 040d", instr_pc, instr);
        end
        @(negedge clk);
        total++; if (instr_pc !== 10'h001) begin bad++; $display("FAIL wrap_001: got %h want 001", instr_pc); end
        branch     = 1'b1;
        br_address = 10'h005;
        stall      = 1'b1;
        @(negedge clk);
        branch = 1'b0;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL brstall_flush: got %b want 0", instr_valid); end
        repeat (2) @(negedge clk);
        total++; if (instr_pc !== 10'h005 || instr !== 16'hA305) begin
            bad++; $display("FAIL brstall_target: got %h %h want 005 a305", instr_pc, instr);
        end
        @(negedge clk);
        total++; if (instr_pc !== 10'h005) begin bad++; $display("FAIL brstall_hold: got %h want 005", instr_pc); end
        stall = 1'b0;
        @(negedge clk);
        total++; if (instr_pc !== 10'h006) begin bad++; $display("FAIL brstall_next: got %h want 006", instr_pc); end
    endtask

    task automatic test_reset_load_mid();
        restart();
        repeat (4) @(negedge clk);
        total++; if (instr_pc !== 10'd2) begin bad++; $display("FAIL mid_pre: got %h want 002", instr_pc); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++; if (instr_valid !== 1'b0 || dbg_count !== 3'd0) begin
            bad++; $display("FAIL mid_reset_flush: got valid %b count %0d want 0 0", instr_valid, dbg_count);
        end
        @(negedge clk);
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_bubble: got %b want 0", instr_valid); end
        @(negedge clk);
        total++; if (instr_pc !== 10'd0 || instr_valid !== 1'b1) begin
            bad++; $display("FAIL mid_reset_restart: got %h/%b want 000/1", instr_pc, instr_valid);
        end
        @(negedge clk);
        load_en    = 1'b1;
        load_addr  = 10'h100;
        load_data  = 16'h1111;
        branch     = 1'b1;
        br_address = 10'h3F0;
        @(negedge clk);
        load_en = 1'b0;
        branch  = 1'b0;
        total++; if (instr_valid !== 1'b0 || dbg_count !== 3'd0) begin
            bad++; $display("FAIL ldbr_flush: got valid %b count %0d want 0 0", instr_valid, dbg_count);
        end
        @(negedge clk);
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL ldbr_bubble: got %b want 0", instr_valid); end
        @(negedge clk);
        total++; if (instr_pc !== 10'd0 || instr !== 16'h040D) begin
            bad++; $display("FAIL ldbr_restart: got %h %h want 000 040d", instr_pc, instr);
        end
        branch     = 1'b1;
        br_address = 10'h100;
        @(negedge clk);
        branch = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (instr_pc !== 10'h100 || instr !== 16'h1111) begin
            bad++; $display("FAIL ldbr_written: got %h %h want 100 1111", instr_pc, instr);
        end
    endtask

    initial begin
        reset      = 1'b1;
        load_en    = 1'b0;
        load_addr  = '0;
        load_data  = '0;
        branch     = 1'b0;
        br_address = '0;
        stall      = 1'b0;
        test_reset();
        test_load_stream();
        test_stall_fill();
        test_branch();
        test_wrap_branch_stall();
        test_reset_load_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
